// File: rtl/envelope_csi_scheduler.sv
// envelope_csi_scheduler
// Shares one cubic-spline interpolation engine between the upper (maxima) and
// lower (minima) envelope paths. Each side buffers extrema in a knot FIFO.
// Whenever a side holds three knots, its three oldest knots are presented to the
// engine as a window. After the engine reports completion, that side's window
// slides forward by one knot. The two sides are served round-robin.
//
// Ports
//   CLK, RST_N                 clock, synchronous active-low reset
//   max_valid/val/pos/ready    maxima knot push interface (side 0, upper)
//   min_valid/val/pos/ready    minima knot push interface (side 1, lower)
//   csi_start                  one-cycle job launch pulse
//   csi_sel                    0 = upper job, 1 = lower job
//   M1..M3 / P1..P3            window values (sign-ext) / positions (zero-ext)
//   csi_done                   engine completion pulse
//   busy                       job in flight (ISSUE, BUSY, RETIRE)
//   order_err                  sticky: a non-increasing position was dropped
module envelope_csi_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        max_valid,
  input  logic [15:0] max_val,
  input  logic [15:0] max_pos,
  output logic        max_ready,
  input  logic        min_valid,
  input  logic [15:0] min_val,
  input  logic [15:0] min_pos,
  output logic        min_ready,
  output logic        csi_start,
  output logic        csi_sel,
  output logic [19:0] M1,
  output logic [19:0] M2,
  output logic [19:0] M3,
  output logic [19:0] P1,
  output logic [19:0] P2,
  output logic [19:0] P3,
  input  logic        csi_done,
  output logic        busy,
  output logic        order_err
);

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 20;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RETIRE} state_t;

  state_t state, state_nxt;

  // Side 0 = upper (maxima), side 1 = lower (minima)
  logic [DW-1:0] fifo_val [2][DEPTH];
  logic [DW-1:0] fifo_pos [2][DEPTH];
  logic [AW-1:0] rptr     [2];
  logic [AW-1:0] wptr     [2];
  logic [CW-1:0] cnt      [2];
  logic [DW-1:0] last_pos [2];
  logic [DW-1:0] in_val   [2];
  logic [DW-1:0] in_pos   [2];
  logic [AW-1:0] rd_idx   [3];

  logic [1:0] in_valid;
  logic [1:0] ready;
  logic [1:0] push;
  logic [1:0] drop;
  logic [1:0] pop;
  logic [1:0] elig;
  logic       grant_pick;
  logic       last_served;

  function automatic logic [OW-1:0] sext(input logic [DW-1:0] x);
    return {{(OW-DW){x[DW-1]}}, x};
  endfunction

  function automatic logic [OW-1:0] zext(input logic [DW-1:0] x);
    return {{(OW-DW){1'b0}}, x};
  endfunction

  // Gather both push interfaces into side-indexed arrays
  always_comb begin
    in_valid  = {min_valid, max_valid};
    in_val[0] = max_val;
    in_val[1] = min_val;
    in_pos[0] = max_pos;
    in_pos[1] = min_pos;
  end

  // Per-side handshake, order check, pop and eligibility
  always_comb begin
    ready = '0;
    push  = '0;
    drop  = '0;
    pop   = '0;
    elig  = '0;
    for (int s = 0; s < 2; s++) begin
      ready[s] = RST_N && (cnt[s] < CW'(DEPTH));
      // Order check only applies when the FIFO holds a previous knot
      drop[s]  = in_valid[s] && ready[s] && (cnt[s] != '0) && (in_pos[s] <= last_pos[s]);
      push[s]  = in_valid[s] && ready[s] && !drop[s];
      pop[s]   = (state == S_RETIRE) && (csi_sel == 1'(s));
      elig[s]  = (cnt[s] >= CW'(3));
    end
  end

  assign max_ready = ready[0];
  assign min_ready = ready[1];

  // Round-robin: on a tie serve the side that was not served last
  always_comb begin
    grant_pick = (&elig) ? ~last_served : elig[1];
    for (int i = 0; i < 3; i++) begin
      rd_idx[i] = rptr[grant_pick] + AW'(i);
    end
  end

  // Knot storage; window slots stay occupied until RETIRE, so no overwrite hazard
  always_ff @(posedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        fifo_val[s][wptr[s]] <= in_val[s];
        fifo_pos[s][wptr[s]] <= in_pos[s];
      end
    end
  end

  // Pointers, occupancy and last accepted position
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int s = 0; s < 2; s++) begin
        rptr[s]     <= '0;
        wptr[s]     <= '0;
        cnt[s]      <= '0;
        last_pos[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          wptr[s]     <= wptr[s] + AW'(1);
          last_pos[s] <= in_pos[s];
        end
        if (pop[s]) begin
          rptr[s] <= rptr[s] + AW'(1);
        end
        cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
      end
    end
  end

  // Sticky order error
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      order_err <= 1'b0;
    end else if (|drop) begin
      order_err <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; csi_done is only honoured in BUSY
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (|elig) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_BUSY;
      S_BUSY:   if (csi_done) state_nxt = S_RETIRE;
      S_RETIRE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    csi_start = 1'b0;
    busy      = 1'b0;
    csi_start = (state == S_ISSUE);
    busy      = (state != S_IDLE);
  end

  // Grant and window are latched at launch and held until the next launch
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      csi_sel     <= 1'b0;
      last_served <= 1'b1;
      M1          <= '0;
      M2          <= '0;
      M3          <= '0;
      P1          <= '0;
      P2          <= '0;
      P3          <= '0;
    end else begin
      if ((state == S_IDLE) && (|elig)) begin
        csi_sel <= grant_pick;
        M1      <= sext(fifo_val[grant_pick][rd_idx[0]]);
        M2      <= sext(fifo_val[grant_pick][rd_idx[1]]);
        M3      <= sext(fifo_val[grant_pick][rd_idx[2]]);
        P1      <= zext(fifo_pos[grant_pick][rd_idx[0]]);
        P2      <= zext(fifo_pos[grant_pick][rd_idx[1]]);
        P3      <= zext(fifo_pos[grant_pick][rd_idx[2]]);
      end
      if (state == S_RETIRE) begin
        last_served <= csi_sel;
      end
    end
  end

endmodule

// File: tb/tb_envelope_csi_scheduler.sv
// Bench for envelope_csi_scheduler: directed scenarios followed by a random
// phase, all checked every cycle against a job-level reference model built
// from knot queues.
module tb_envelope_csi_scheduler;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        max_valid, min_valid, csi_done;
  logic [15:0] max_val, max_pos, min_val, min_pos;
  logic        max_ready, min_ready, csi_start, csi_sel, busy, order_err;
  logic [19:0] M1, M2, M3, P1, P2, P3;

  envelope_csi_scheduler #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .max_valid(max_valid), .max_val(max_val), .max_pos(max_pos), .max_ready(max_ready),
    .min_valid(min_valid), .min_val(min_val), .min_pos(min_pos), .min_ready(min_ready),
    .csi_start(csi_start), .csi_sel(csi_sel),
    .M1(M1), .M2(M2), .M3(M3), .P1(P1), .P2(P2), .P3(P3),
    .csi_done(csi_done), .busy(busy), .order_err(order_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [15:0] v; logic [15:0] p;} knot_t;

  // Reference model: knot queues plus job phase (0 idle, 1 launch, 2 wait, 3 retire)
  knot_t       q [2][$];
  int          ph;
  bit          g, ls, err, esel;
  logic [15:0] lp [2];
  logic [19:0] em [3];
  logic [19:0] ep [3];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [19:0] sx(input logic [15:0] v);
    return {{4{v[15]}}, v};
  endfunction

  task automatic model_reset();
    q[0].delete();
    q[1].delete();
    ph = 0; g = 0; ls = 1; err = 0; esel = 0;
    lp[0] = '0; lp[1] = '0;
    for (int i = 0; i < 3; i++) begin em[i] = '0; ep[i] = '0; end
  endtask

  task automatic model_check(input bit rn);
    chk("csi_start", 32'(csi_start), 32'(ph == 1));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("max_ready", 32'(max_ready), 32'(rn && (q[0].size() < DEPTH)));
    chk("min_ready", 32'(min_ready), 32'(rn && (q[1].size() < DEPTH)));
    chk("order_err", 32'(order_err), 32'(err));
    chk("csi_sel", 32'(csi_sel), 32'(esel));
    chk("M1", 32'(M1), 32'(em[0]));
    chk("M2", 32'(M2), 32'(em[1]));
    chk("M3", 32'(M3), 32'(em[2]));
    chk("P1", 32'(P1), 32'(ep[0]));
    chk("P2", 32'(P2), 32'(ep[1]));
    chk("P3", 32'(P3), 32'(ep[2]));
  endtask

  // Apply what happens at the coming clock edge
  task automatic model_edge(input bit rn, input bit mv, input logic [15:0] mval, input logic [15:0] mpos,
                            input bit nv, input logic [15:0] nval, input logic [15:0] npos, input bit dn);
    int  sz [2];
    bit  v [2];
    knot_t k [2];
    if (!rn) begin
      model_reset();
      return;
    end
    sz[0] = q[0].size(); sz[1] = q[1].size();
    v[0] = mv; v[1] = nv;
    k[0] = '{v: mval, p: mpos};
    k[1] = '{v: nval, p: npos};
    case (ph)
      0: if (sz[0] >= 3 || sz[1] >= 3) begin
           g = (sz[0] >= 3 && sz[1] >= 3) ? !ls : (sz[1] >= 3);
           esel = g;
           for (int i = 0; i < 3; i++) begin
             em[i] = sx(q[g][i].v);
             ep[i] = {4'h0, q[g][i].p};
           end
           ph = 1;
         end
      1: ph = 2;
      2: if (dn) ph = 3;
      default: begin
        void'(q[g].pop_front());
        ls = g;
        ph = 0;
      end
    endcase
    for (int s = 0; s < 2; s++) begin
      if (v[s] && sz[s] < DEPTH) begin
        if (sz[s] > 0 && k[s].p <= lp[s]) err = 1;
        else begin
          q[s].push_back(k[s]);
          lp[s] = k[s].p;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance model and clock
  task automatic step(input bit rn, input bit mv, input logic [15:0] mval, input logic [15:0] mpos,
                      input bit nv, input logic [15:0] nval, input logic [15:0] npos, input bit dn);
    RST_N = rn;
    max_valid = mv; max_val = mval; max_pos = mpos;
    min_valid = nv; min_val = nval; min_pos = npos;
    csi_done = dn;
    #1;
    model_check(rn);
    model_edge(rn, mv, mval, mpos, nv, nval, npos, dn);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
  endtask

  task automatic pmax(input logic [15:0] v, input logic [15:0] p, input bit dn);
    step(1, 1, v, p, 0, 16'd0, 16'd0, dn);
  endtask

  task automatic pmin(input logic [15:0] v, input logic [15:0] p, input bit dn);
    step(1, 0, 16'd0, 16'd0, 1, v, p, dn);
  endtask

  initial begin
    logic [15:0] mp, np;
    bit sels [$];
    RST_N = 0; max_valid = 0; min_valid = 0; csi_done = 0;
    max_val = '0; max_pos = '0; min_val = '0; min_pos = '0;
    model_reset();
    @(posedge CLK);
    #1;
    rst(2);

    // Upper window launch and slide by one knot
    pmax(16'd100, 16'd5, 0);
    pmax(-16'sd20, 16'd9, 0);
    pmax(16'd300, 16'd14, 0);
    idle(1);
    chk("first_start", 32'(csi_start), 32'd1);
    chk("first_sel", 32'(csi_sel), 32'd0);
    chk("first_M2", 32'(M2), 32'h000FFFEC);
    chk("first_P3", 32'(P3), 32'd14);
    idle(1);
    pmax(16'd50, 16'd20, 0);
    idle(1);
    step(1, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1);
    idle(2);
    chk("second_start", 32'(csi_start), 32'd1);
    chk("second_P1", 32'(P1), 32'd9);
    chk("second_P3", 32'(P3), 32'd20);
    chk("second_M3", 32'(M3), 32'd50);
    idle(1);
    step(1, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1);
    idle(1);
    chk("back_idle", 32'(busy), 32'd0);

    // Both sides eligible: strict alternation starting with upper
    rst(1);
    mp = 16'd1; np = 16'd1;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 16'(i), mp, 1, 16'(i + 100), np, 0);
      mp++; np++;
    end
    idle(1);
    for (int i = 0; i < 24; i++) begin
      if (csi_start) sels.push_back(csi_sel);
      step(1, 1, 16'(i), mp, 1, 16'(i + 7), np, 1);
      mp++; np++;
    end
    chk("rr_jobs", 32'(sels.size()), 32'd6);
    foreach (sels[k]) chk("rr_alternate", 32'(sels[k]), 32'(k % 2));

    // Minima FIFO full while its job is outstanding
    rst(1);
    pmin(16'd1, 16'd10, 0);
    pmin(16'd2, 16'd11, 0);
    pmin(16'd3, 16'd12, 0);
    idle(1);
    pmin(16'd4, 16'd13, 0);
    chk("full_ready", 32'(min_ready), 32'd0);
    pmin(16'd5, 16'd14, 0);
    pmin(16'd5, 16'd14, 1);
    chk("retire_ready", 32'(min_ready), 32'd0);
    pmin(16'd5, 16'd14, 0);
    chk("after_pop_ready", 32'(min_ready), 32'd1);
    idle(4);

    // Push during RETIRE on a non-full side keeps it eligible
    rst(1);
    pmax(16'd1, 16'd1, 0);
    pmax(16'd2, 16'd2, 0);
    pmax(16'd3, 16'd3, 0);
    idle(2);
    step(1, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1);
    pmax(16'd4, 16'd4, 0);
    idle(1);
    chk("retire_push_start", 32'(csi_start), 32'd1);
    chk("retire_push_P3", 32'(P3), 32'd4);
    idle(4);

    // Non-increasing position is dropped and flagged
    rst(1);
    pmin(16'd7, 16'd30, 0);
    pmin(16'd8, 16'd30, 0);
    chk("order_err_set", 32'(order_err), 32'd1);
    pmin(16'd9, 16'd31, 0);
    pmin(16'd10, 16'd32, 0);
    idle(2);
    chk("order_P1", 32'(P1), 32'd30);
    chk("order_P2", 32'(P2), 32'd31);
    idle(4);

    // Reset during BUSY, then a stale csi_done
    rst(1);
    pmax(16'd1, 16'd1, 0);
    pmax(16'd2, 16'd2, 0);
    pmax(16'd3, 16'd3, 0);
    idle(2);
    rst(1);
    step(1, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1);
    idle(4);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_start", 32'(csi_start), 32'd0);

    // Random phase against the model
    mp = 16'd0; np = 16'd0;
    for (int i = 0; i < 400; i++) begin
      bit rn, mv, nv, dn;
      rn = ($urandom_range(0, 99) != 0);
      mv = $urandom_range(0, 1);
      nv = $urandom_range(0, 1);
      dn = ($urandom_range(0, 2) == 0);
      if (mv) mp = mp + 16'($urandom_range(0, 4));
      if (nv) np = np + 16'($urandom_range(0, 4));
      step(rn, mv, 16'($urandom), mp, nv, 16'($urandom), np, dn);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
